lsu_master: RTL and testbench

- CPU-side load/store initiator for the data-memory word port.
- Accepts one M-stage load/store request at a time.
- Forms the word-aligned address, the byte enables and the lane-positioned store data.
- Runs a valid/ready request and rvalid response handshake with the memory, then returns sign/zero-extended load data or an address exception to the pipeline.

---
 rtl/lsu_pkg.sv | 53 +++++
 rtl/lsu_lane.sv | 53 +++++
 rtl/lsu_master.sv | 190 +++++++++++++++++++
 tb/tb_lsu_master.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the data-memory load/store initiator.
// Size codes, FSM states, exception codes and access-width decode.
package lsu_pkg;

    // Load size codes
    localparam logic [2:0] SZ_WORD  = 3'b000;
    localparam logic [2:0] SZ_SHALF = 3'b001;
    localparam logic [2:0] SZ_UHALF = 3'b010;
    localparam logic [2:0] SZ_SBYTE = 3'b011;
    localparam logic [2:0] SZ_UBYTE = 3'b100;

    // Store size codes
    localparam logic [2:0] SZ_ST_HALF = 3'b001;
    localparam logic [2:0] SZ_ST_BYTE = 3'b010;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        W_BYTE,
        W_HALF,
        W_WORD
    } width_e;

    // Loads and stores use different size encodings; unused codes act as word.
    function automatic width_e access_width(input logic we, input logic [2:0] size);
        width_e w;
        w = W_WORD;
        if (we) begin
            case (size)
                SZ_ST_HALF: w = W_HALF;
                SZ_ST_BYTE: w = W_BYTE;
                default:    w = W_WORD;
            endcase
        end else begin
            case (size)
                SZ_SHALF, SZ_UHALF: w = W_HALF;
                SZ_SBYTE, SZ_UBYTE: w = W_BYTE;
                default:            w = W_WORD;
            endcase
        end
        return w;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: store byte enables / data placement and
// load half/byte extraction with sign or zero extension.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    input  logic [2:0]  ld_size,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] rdata_ext
);

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    always_comb begin
        be         = '0;
        lane_wdata = '0;
        case (access_width(we, size))
            W_HALF: begin
                be         = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
            end
            W_BYTE: begin
                be         = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
            end
            default: begin
                be         = 4'b1111;
                lane_wdata = wdata;
            end
        endcase
    end

    always_comb begin
        half_sel  = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
        byte_sel  = rdata[{ld_addr_lo, 3'b000} +: 8];
        rdata_ext = rdata;
        case (ld_size)
            SZ_SHALF: rdata_ext = {{16{half_sel[15]}}, half_sel};
            SZ_UHALF: rdata_ext = {16'h0000, half_sel};
            SZ_SBYTE: rdata_ext = {{24{byte_sel[7]}}, byte_sel};
            SZ_UBYTE: rdata_ext = {24'h00_0000, byte_sel};
            default:  rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_master.sv
// CPU-side load/store initiator: one request at a time, valid/ready issue,
// rvalid response. Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_master
    import lsu_pkg::*;
#(
    parameter logic [31:0] ADDR_LO = 32'h0000_0000,
    parameter logic [31:0] ADDR_HI = 32'h0000_2FFF
`ifdef LSU_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 16
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_exc,
    output logic [4:0]  rsp_exc_code,
    output logic [31:0] rsp_pc
);

    state_e      state;
    logic [2:0]  size_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] pc_q;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] rdata_ext;
    width_e      req_width;
    logic        addr_bad;

`ifdef LSU_TIMEOUT_EN
    logic [4:0]  tmo_cnt;
    logic        tmo_hit;
    assign tmo_hit = (tmo_cnt == 5'(TIMEOUT - 1));
`endif

    lsu_lane u_lane (
        .we         (req_we),
        .size       (req_size),
        .addr_lo    (req_addr[1:0]),
        .wdata      (req_wdata),
        .be         (lane_be),
        .lane_wdata (lane_wdata),
        .ld_size    (size_q),
        .ld_addr_lo (addr_lo_q),
        .rdata      (mem_rdata),
        .rdata_ext  (rdata_ext)
    );

    // Single unsigned compare covers both bounds: below ADDR_LO wraps high.
    always_comb begin
        req_width = access_width(req_we, req_size);
        addr_bad  = ((req_width == W_WORD) && (req_addr[1:0] != 2'b00)) ||
                    ((req_width == W_HALF) && req_addr[0]) ||
                    ((req_addr - ADDR_LO) > (ADDR_HI - ADDR_LO));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            req_ready    <= 1'b1;
            mem_valid    <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_be       <= '0;
            mem_wdata    <= '0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_exc      <= 1'b0;
            rsp_exc_code <= '0;
            rsp_pc       <= '0;
            size_q       <= '0;
            addr_lo_q    <= '0;
            pc_q         <= '0;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        size_q    <= req_size;
                        addr_lo_q <= req_addr[1:0];
                        pc_q      <= req_pc;
                        if (addr_bad) begin
                            state        <= S_RESP;
                            rsp_valid    <= 1'b1;
                            rsp_exc      <= 1'b1;
                            rsp_exc_code <= req_we ? EXC_ADES : EXC_ADEL;
                            rsp_rdata    <= '0;
                            rsp_pc       <= req_pc;
                        end else begin
                            state     <= S_ISSUE;
                            mem_valid <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= lane_be;
                            mem_wdata <= req_we ? lane_wdata : '0;
`ifdef LSU_TIMEOUT_EN
                            tmo_cnt   <= '0;
`endif
                        end
                    end
                end
                S_ISSUE: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= '0;
`ifdef LSU_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                        if (mem_we) begin
                            state        <= S_RESP;
                            rsp_valid    <= 1'b1;
                            rsp_exc      <= 1'b0;
                            rsp_exc_code <= '0;
                            rsp_rdata    <= '0;
                            rsp_pc       <= pc_q;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state        <= S_RESP;
                        mem_valid    <= 1'b0;
                        mem_we       <= 1'b0;
                        mem_be       <= '0;
                        rsp_valid    <= 1'b1;
                        rsp_exc      <= 1'b1;
                        rsp_exc_code <= EXC_DBE;
                        rsp_rdata    <= '0;
                        rsp_pc       <= pc_q;
                    end else begin
                        tmo_cnt <= tmo_cnt + 5'd1;
                    end
`endif
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        state        <= S_RESP;
                        rsp_valid    <= 1'b1;
                        rsp_exc      <= 1'b0;
                        rsp_exc_code <= '0;
                        rsp_rdata    <= rdata_ext;
                        rsp_pc       <= pc_q;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state        <= S_RESP;
                        rsp_valid    <= 1'b1;
                        rsp_exc      <= 1'b1;
                        rsp_exc_code <= EXC_DBE;
                        rsp_rdata    <= '0;
                        rsp_pc       <= pc_q;
                    end else begin
                        tmo_cnt <= tmo_cnt + 5'd1;
                    end
`endif
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_exc   <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_master.sv
// Directed self-checking bench for lsu_master (default build; timeout
// scenario runs only when LSU_TIMEOUT_EN is defined).
module tb_lsu_master;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_exc;
    logic [4:0]  rsp_exc_code;
    logic [31:0] rsp_pc;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        exc;
        logic [4:0]  code;
        logic [31:0] pc;
        int          lat;
        logic        saw_mv;
        logic        stable;
        logic        ready_at_rsp;
        logic [31:0] maddr;
        logic [3:0]  mbe;
        logic [31:0] mwdata;
        logic        mwe;
    } obs_t;

    lsu_master #(
        .ADDR_LO(32'h0000_0000),
        .ADDR_HI(32'h0000_2FFF)
`ifdef LSU_TIMEOUT_EN
        ,
        .TIMEOUT(16)
`endif
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_pc       (req_pc),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_exc      (rsp_exc),
        .rsp_exc_code (rsp_exc_code),
        .rsp_pc       (rsp_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request and plays the memory side; records what it observed.
    // lat counts negedges from the accept edge to rsp_valid (0 = never seen).
    task automatic run_req(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] pc, input logic [31:0] rdata,
                           input int ready_delay, input logic give_rvalid, output obs_t o);
        int   wait_cnt;
        logic seen;
        o.rdata = '0; o.exc = 1'b0; o.code = '0; o.pc = '0; o.lat = 0;
        o.saw_mv = 1'b0; o.stable = 1'b1; o.ready_at_rsp = 1'b1;
        o.maddr = '0; o.mbe = '0; o.mwdata = '0; o.mwe = 1'b0;
        wait_cnt = 0;
        seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr;
        req_wdata = wdata; req_pc = pc;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            req_valid  = 1'b0;
            mem_rvalid = 1'b0;
            if (mem_ready) begin
                mem_ready = 1'b0;
                if (!we && give_rvalid) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rdata;
                end
            end
            if (mem_valid) begin
                o.saw_mv = 1'b1;
                if (!seen) begin
                    seen = 1'b1;
                    o.maddr = mem_addr; o.mbe = mem_be; o.mwdata = mem_wdata; o.mwe = mem_we;
                end else if (mem_addr !== o.maddr || mem_be !== o.mbe ||
                             mem_wdata !== o.mwdata || mem_we !== o.mwe) begin
                    o.stable = 1'b0;
                end
                if (wait_cnt >= ready_delay) mem_ready = 1'b1;
                wait_cnt++;
            end
            if (rsp_valid) begin
                o.lat = k; o.rdata = rsp_rdata; o.exc = rsp_exc; o.code = rsp_exc_code;
                o.pc = rsp_pc; o.ready_at_rsp = req_ready;
                break;
            end
        end
        mem_rvalid = 1'b0;
        mem_ready  = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready got=%b exp=1", req_ready); else passed++;
        total++; if (mem_valid !== 1'b0) $display("FAIL rst_mem_valid got=%b exp=0", mem_valid); else passed++;
        total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got=%b exp=0", mem_we); else passed++;
        total++; if (mem_be !== 4'h0) $display("FAIL rst_mem_be got=%h exp=0", mem_be); else passed++;
        total++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); else passed++;
        total++; if (rsp_valid !== 1'b0 || rsp_exc !== 1'b0) $display("FAIL rst_rsp got=%b%b exp=00", rsp_valid, rsp_exc); else passed++;
        total++; if (rsp_pc !== 32'h0 || rsp_rdata !== 32'h0) $display("FAIL rst_rsp_data got=%h/%h exp=0/0", rsp_pc, rsp_rdata); else passed++;
        reset = 1'b1;
    endtask

    task automatic test_load_word();
        obs_t o;
        run_req(1'b0, 3'b000, 32'h0000_0100, 32'h0, 32'h0000_0400, 32'hDEAD_BEEF, 0, 1'b1, o);
        total++; if (o.lat !== 3) $display("FAIL lw_latency got=%0d exp=3", o.lat); else passed++;
        total++; if (o.rdata !== 32'hDEAD_BEEF) $display("FAIL lw_rdata got=%h exp=deadbeef", o.rdata); else passed++;
        total++; if (o.exc !== 1'b0) $display("FAIL lw_exc got=%b exp=0", o.exc); else passed++;
        total++; if (o.pc !== 32'h0000_0400) $display("FAIL lw_pc got=%h exp=00000400", o.pc); else passed++;
        total++; if (o.maddr !== 32'h0000_0100 || o.mwe !== 1'b0) $display("FAIL lw_mem got=%h/%b exp=00000100/0", o.maddr, o.mwe); else passed++;
        total++; if (o.ready_at_rsp !== 1'b0) $display("FAIL lw_ready_busy got=%b exp=0", o.ready_at_rsp); else passed++;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) $display("FAIL lw_pulse_width got=%b exp=0", rsp_valid); else passed++;
        total++; if (req_ready !== 1'b1) $display("FAIL lw_ready_idle got=%b exp=1", req_ready); else passed++;
    endtask

    task automatic test_load_extend();
        obs_t o;
        logic [2:0]  sz  [5] = '{3'b011, 3'b010, 3'b001, 3'b100, 3'b101};
        logic [31:0] ad  [5] = '{32'h103, 32'h102, 32'h100, 32'h101, 32'h104};
        logic [31:0] rd  [5] = '{32'h80FF_0000, 32'h80FF_0000, 32'h0000_8001, 32'h0000_F100, 32'h1234_5678};
        logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_80FF, 32'hFFFF_8001, 32'h0000_00F1, 32'h1234_5678};
        for (int i = 0; i < 5; i++) begin
            run_req(1'b0, sz[i], ad[i], 32'h0, 32'h500 + 32'(i), rd[i], 0, 1'b1, o);
            total++; if (o.rdata !== exp[i] || o.exc !== 1'b0) $display("FAIL ld_ext_%0d got=%h exc=%b exp=%h exc=0", i, o.rdata, o.exc, exp[i]); else passed++;
            total++; if (o.lat !== 3) $display("FAIL ld_ext_lat_%0d got=%0d exp=3", i, o.lat); else passed++;
        end
        run_req(1'b0, 3'b011, 32'h0000_2FFF, 32'h0, 32'h600, 32'h7F00_0000, 0, 1'b1, o);
        total++; if (o.rdata !== 32'h0000_007F || o.exc !== 1'b0) $display("FAIL ld_top_byte got=%h exc=%b exp=0000007f exc=0", o.rdata, o.exc); else passed++;
        total++; if (o.maddr !== 32'h0000_2FFC) $display("FAIL ld_top_addr got=%h exp=00002ffc", o.maddr); else passed++;
    endtask

    task automatic test_store_lanes();
        obs_t o;
        run_req(1'b1, 3'b010, 32'h0000_0201, 32'hAABB_CC5A, 32'h700, 32'h0, 0, 1'b0, o);
        total++; if (o.mbe !== 4'b0010) $display("FAIL sb_be got=%b exp=0010", o.mbe); else passed++;
        total++; if (o.mwdata !== 32'h5A5A_5A5A) $display("FAIL sb_wdata got=%h exp=5a5a5a5a", o.mwdata); else passed++;
        total++; if (o.maddr !== 32'h0000_0200 || o.mwe !== 1'b1) $display("FAIL sb_addr got=%h/%b exp=00000200/1", o.maddr, o.mwe); else passed++;
        total++; if (o.lat !== 2 || o.rdata !== 32'h0 || o.pc !== 32'h700) $display("FAIL sb_rsp got=lat%0d %h %h exp=lat2 0 700", o.lat, o.rdata, o.pc); else passed++;
        run_req(1'b1, 3'b001, 32'h0000_0202, 32'hFFFF_1234, 32'h704, 32'h0, 0, 1'b0, o);
        total++; if (o.mbe !== 4'b1100) $display("FAIL sh_hi_be got=%b exp=1100", o.mbe); else passed++;
        total++; if (o.mwdata[31:16] !== 16'h1234) $display("FAIL sh_hi_wdata got=%h exp=1234", o.mwdata[31:16]); else passed++;
        run_req(1'b1, 3'b001, 32'h0000_0200, 32'h0000_BEEF, 32'h708, 32'h0, 0, 1'b0, o);
        total++; if (o.mbe !== 4'b0011 || o.mwdata[15:0] !== 16'hBEEF) $display("FAIL sh_lo got=%b/%h exp=0011/beef", o.mbe, o.mwdata[15:0]); else passed++;
        run_req(1'b1, 3'b000, 32'h0000_2FFC, 32'hCAFE_F00D, 32'h70C, 32'h0, 0, 1'b0, o);
        total++; if (o.mbe !== 4'b1111 || o.mwdata !== 32'hCAFE_F00D) $display("FAIL sw_top got=%b/%h exp=1111/cafef00d", o.mbe, o.mwdata); else passed++;
        total++; if (o.lat !== 2 || o.exc !== 1'b0) $display("FAIL sw_top_rsp got=lat%0d exc=%b exp=lat2 exc=0", o.lat, o.exc); else passed++;
    endtask

    task automatic test_exceptions();
        obs_t o;
        logic        we  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [2:0]  sz  [5] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b001};
        logic [31:0] ad  [5] = '{32'h0000_0102, 32'h0000_3000, 32'h0000_0101, 32'h0000_3000, 32'h0000_0203};
        logic [4:0]  cd  [5] = '{5'd4, 5'd5, 5'd4, 5'd5, 5'd5};
        for (int i = 0; i < 5; i++) begin
            run_req(we[i], sz[i], ad[i], 32'hFFFF_FFFF, 32'h800 + 32'(i), 32'hFFFF_FFFF, 0, 1'b1, o);
            total++; if (o.exc !== 1'b1 || o.code !== cd[i]) $display("FAIL exc_code_%0d got=%b/%0d exp=1/%0d", i, o.exc, o.code, cd[i]); else passed++;
            total++; if (o.saw_mv !== 1'b0) $display("FAIL exc_no_mem_%0d got=%b exp=0", i, o.saw_mv); else passed++;
            total++; if (o.lat !== 1 || o.rdata !== 32'h0 || o.pc !== 32'h800 + 32'(i)) $display("FAIL exc_rsp_%0d got=lat%0d %h %h exp=lat1 0 %h", i, o.lat, o.rdata, o.pc, 32'h800 + 32'(i)); else passed++;
        end
    endtask

    task automatic test_ready_stall();
        obs_t o;
        run_req(1'b0, 3'b000, 32'h0000_0110, 32'h0, 32'h900, 32'h0BAD_F00D, 5, 1'b1, o);
        total++; if (o.stable !== 1'b1) $display("FAIL stall_ld_stable got=%b exp=1", o.stable); else passed++;
        total++; if (o.lat !== 8 || o.rdata !== 32'h0BAD_F00D) $display("FAIL stall_ld_rsp got=lat%0d %h exp=lat8 0badf00d", o.lat, o.rdata); else passed++;
        run_req(1'b1, 3'b000, 32'h0000_0300, 32'hA5A5_0F0F, 32'h904, 32'h0, 5, 1'b0, o);
        total++; if (o.stable !== 1'b1 || o.mwdata !== 32'hA5A5_0F0F) $display("FAIL stall_st_stable got=%b/%h exp=1/a5a50f0f", o.stable, o.mwdata); else passed++;
        total++; if (o.lat !== 7) $display("FAIL stall_st_lat got=%0d exp=7", o.lat); else passed++;
    endtask

    task automatic test_reset_midflight();
        int seen;
        // Reset while a store is still waiting for mem_ready.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 3'b000; req_addr = 32'h0000_0400;
        req_wdata = 32'h1111_2222; req_pc = 32'hA00;
        @(negedge clk);
        req_valid = 1'b0;
        total++; if (mem_valid !== 1'b1) $display("FAIL rst_issue_pre got=%b exp=1", mem_valid); else passed++;
        #2 reset = 1'b0;
        #1;
        total++; if (mem_valid !== 1'b0 || mem_we !== 1'b0) $display("FAIL rst_issue_drop got=%b%b exp=00", mem_valid, mem_we); else passed++;
        total++; if (mem_wdata !== 32'h0 || mem_addr !== 32'h0) $display("FAIL rst_issue_data got=%h/%h exp=0/0", mem_wdata, mem_addr); else passed++;
        @(negedge clk);
        reset = 1'b1;
        // Reset while a load sits in WAIT.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 3'b000; req_addr = 32'h0000_0100;
        req_pc = 32'hB00;
        @(negedge clk);
        req_valid = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        total++; if (mem_addr !== 32'h0 || mem_be !== 4'h0) $display("FAIL rst_wait_mem got=%h/%b exp=0/0000", mem_addr, mem_be); else passed++;
        total++; if (rsp_valid !== 1'b0 || rsp_exc !== 1'b0 || rsp_pc !== 32'h0) $display("FAIL rst_wait_rsp got=%b%b/%h exp=00/0", rsp_valid, rsp_exc, rsp_pc); else passed++;
        total++; if (req_ready !== 1'b1) $display("FAIL rst_wait_ready got=%b exp=1", req_ready); else passed++;
        @(negedge clk);
        reset = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (rsp_valid === 1'b1) seen++;
        end
        total++; if (seen !== 0) $display("FAIL rst_no_rsp got=%0d exp=0", seen); else passed++;
        total++; if (req_ready !== 1'b1 || mem_valid !== 1'b0) $display("FAIL rst_idle_after got=%b%b exp=10", req_ready, mem_valid); else passed++;
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        int   seen;
        run_req(1'b0, 3'b000, 32'h0000_0120, 32'h0, 32'hC00, 32'h0, 0, 1'b0, o);
        total++; if (o.lat !== 18) $display("FAIL tmo_latency got=%0d exp=18", o.lat); else passed++;
        total++; if (o.exc !== 1'b1 || o.code !== 5'd7) $display("FAIL tmo_code got=%b/%0d exp=1/7", o.exc, o.code); else passed++;
        total++; if (o.rdata !== 32'h0 || o.pc !== 32'hC00) $display("FAIL tmo_rsp got=%h/%h exp=0/c00", o.rdata, o.pc); else passed++;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (rsp_valid === 1'b1) seen++;
        end
        total++; if (seen !== 0) $display("FAIL tmo_late_rvalid got=%0d exp=0", seen); else passed++;
    endtask
`endif

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 3'b000; req_addr = '0;
        req_wdata = '0; req_pc = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        test_reset();
        test_load_word();
        test_load_extend();
        test_store_lanes();
        test_exceptions();
        test_ready_stall();
        test_reset_midflight();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
